immenc: RTL and testbench
=========================

# immenc

Immediate/instruction encoder for the RV32I core: packs a register/immediate request into a legal 32-bit instruction word. It range-checks immediates and expands the LI pseudo-instruction into LUI+ADDI. It sits between the test-program loader/self-test sequencer and instruction memory, with valid/ready on both sides. Round-trip output through the core's immediate decoding is the reference check.

## Interface
- No parameters.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid && ready
- fmt_i  in  3  format: I=0, S=1, B=2, U=3, J=4, R=5, LI=6; 7 reserved, treated as error
- opcode_i  in  7  opcode; ignored for LI
- funct3_i  in  3  funct3; ignored for U/J/LI
- funct7_i  in  7  funct7; used for R only
- rd_i, rs1_i, rs2_i  in  5 each  register indices
- imm_i  in  32  signed immediate; for U it is the full value with bits [11:0] zero
- instr_valid_o  out  1  instruction valid
- instr_ready_i  in  1  sink ready
- instr_o  out  32  encoded instruction
- err_o  out  1  one-cycle pulse: request rejected
- err_cnt_o  out  8  saturating count of rejected requests

## Operation
- FSM states: IDLE, EMIT, EMIT_LO.
- req_ready_o = (state == IDLE).
- On accept:
  - Legal non-LI request, or LI whose immediate fits 12-bit signed or has bits [11:0] zero: register the single word, go to EMIT.
  - LI needing two words: register LUI, latch the ADDI word, go to EMIT.
  - Illegal request: stay IDLE, pulse err_o, err_cnt_o += 1 saturating at 255.
- EMIT, on instr_valid_o && instr_ready_i: go to EMIT_LO if an ADDI is pending, else IDLE.
- EMIT_LO: present the ADDI word; on handshake go to IDLE.
- Range rules:
  - I/S: −2048..2047.
  - B: −4096..4094, even.
  - J: −1048576..1048574, even.
  - U: imm_i[11:0] == 0.
  - R/LI: always legal.
- LI encoding:
  - If −2048..2047: ADDI rd, x0, imm.
  - Else: hi = (imm_i + 0x800)[31:12], giving LUI rd, hi.
  - If imm_i[11:0] != 0, follow with ADDI rd, rd, imm_i[11:0]. Arithmetic is 32-bit modulo.
- Bit scatter per format is the exact inverse of RV32I immediate decoding. B/J drop imm[0]; the sign bit goes to bit 31.

## Timing
- Reset values: req_ready_o=1, instr_valid_o=0, instr_o=0, err_o=0, err_cnt_o=0, state IDLE.
- Latency: instr_valid_o rises in the cycle after acceptance. err_o pulses in the cycle after acceptance.
- instr_o is held stable while instr_valid_o && !instr_ready_i. instr_valid_o never drops without a handshake, except on reset.
- Throughput: one request per 2 cycles at best. LI with two words takes at least 3 cycles.
- After the last handshake, req_ready_o rises in the next cycle.
- Reset mid-operation: next edge returns to IDLE, clears instr_valid_o, discards any pending ADDI.
- err_cnt_o at 255 holds 255; err_o still pulses.

## Configuration
- IMMENC_RANGE_CHECK_EN defined:
  - Range rules are enforced as above.
  - Reserved fmt is also rejected.
- IMMENC_RANGE_CHECK_EN undefined:
  - No range checks; immediates are silently truncated to the format's field bits.
  - Reserved fmt emits 0x00000013 (NOP).
  - err_o and err_cnt_o are tied to 0.
  - LI expansion is unchanged.

## Structure
- immenc_pkg holds:
  - fmt_e enum.
  - Opcode constants OP_LUI=7'b0110111 and OP_IMM=7'b0010011.
  - Range bound localparams.
  - The NOP constant.
- Sub-module immenc_pack: purely combinational. Inputs: fmt, fields, imm. Outputs: word, in_range flag. It is instantiated once in the FSM datapath and called twice for LI, muxing fields into it.

## Test plan
- I-type ADDI, rd=5, rs1=0, funct3=0, imm=0xFFFFFFFF, sink ready → instr_o=0xFFF00293 one cycle after accept; err_o=0.
- B-type opcode 1100011, rs1=1, rs2=2, funct3=0, imm=8 → 0x00208463.
- LI rd=1, imm=0x12345FFF → 0x123460B7, then 0xFFF08093. LI imm=0x00005000 → single 0x000050B7. LI imm=−5 → single 0xFFB00093.
- I-type imm=2048, macro on → err_o one-cycle pulse, no instr_valid_o, err_cnt_o=1. Macro off → 0x80000293.
- LI 0x12345FFF with instr_ready_i low for 3 cycles → instr_o holds 0x123460B7, valid held, req_ready_o=0. The ADDI word appears only after the handshake.
- rst_i asserted in EMIT_LO of LI → next cycle instr_valid_o=0, req_ready_o=1, err_cnt_o=0. The ADDI word is never emitted.

Source files
------------

// File: rtl/immenc_pkg.sv
// immenc_pkg: shared types and constants for the RV32I immediate/instruction
// encoder (immenc, immenc_pack).
//   fmt_e      request format codes as carried on fmt_i
//   state_e    encoder FSM states
//   OP_LUI/OP_IMM, NOP, immediate range bounds, fits12() helper
package immenc_pkg;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_R   = 3'd5,
        FMT_LI  = 3'd6,
        FMT_RSV = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        EMIT_LO = 2'd2
    } state_e;

    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam int I_MIN = -2048;
    localparam int I_MAX = 2047;
    localparam int B_MIN = -4096;
    localparam int B_MAX = 4094;
    localparam int J_MIN = -1048576;
    localparam int J_MAX = 1048574;

    // True when v is representable as a 12-bit signed immediate.
    function automatic logic fits12(input logic [31:0] v);
        return (v[31:11] == '0) || (v[31:11] == '1);
    endfunction

endpackage

// File: rtl/immenc_pack.sv
// immenc_pack: combinational bit scatter of one RV32I instruction word.
// Optional feature macro: IMMENC_RANGE_CHECK_EN (enables in_range checking;
// without it in_range is always 1 and immediates are truncated to field bits).
//   fmt                 format selector (fmt_e); LI/reserved produce NOP
//   opcode/funct3/funct7, rd/rs1/rs2, imm   instruction fields
//   word                encoded instruction
//   in_range            immediate legal for the selected format
import immenc_pkg::*;

module immenc_pack (
    input  fmt_e        fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        in_range
);

    always_comb begin
        word = NOP;
        case (fmt)
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3,
                           imm[4:1], imm[11], opcode};
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            default: word = NOP;
        endcase
    end

`ifdef IMMENC_RANGE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm;

    always_comb begin
        in_range = 1'b0;
        case (fmt)
            FMT_I, FMT_S: in_range = (simm >= I_MIN) && (simm <= I_MAX);
            FMT_B:        in_range = (simm >= B_MIN) && (simm <= B_MAX) && !imm[0];
            FMT_J:        in_range = (simm >= J_MIN) && (simm <= J_MAX) && !imm[0];
            FMT_U:        in_range = (imm[11:0] == '0);
            FMT_R, FMT_LI: in_range = 1'b1;
            default:      in_range = 1'b0;
        endcase
    end
`else
    assign in_range = 1'b1;
`endif

endmodule

// File: rtl/immenc.sv
// immenc: RV32I immediate/instruction encoder with LI expansion.
// Optional feature macro: IMMENC_RANGE_CHECK_EN (range checks, error pulse and
// saturating error counter; without it err_o/err_cnt_o are tied to 0).
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      request handshake
//   fmt_i, opcode_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i  request
//   instr_valid_o/instr_ready_i  instruction handshake, instr_o word
//   err_o, err_cnt_o             reject pulse and saturating reject count
import immenc_pkg::*;

module immenc (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  fmt_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    state_e      state;
    logic        pend;        // ADDI still owed after the LUI
    logic [4:0]  pend_rd;
    logic [11:0] pend_lo;

    fmt_e        req_fmt;
    logic        li_small;
    logic        addi_sel;

    fmt_e        p_fmt;
    logic [6:0]  p_opcode;
    logic [2:0]  p_funct3;
    logic [4:0]  p_rs1;
    logic [31:0] p_imm;
    logic [31:0] p_word;
    logic        in_range;

    assign req_fmt     = fmt_e'(fmt_i);
    assign li_small    = fits12(imm_i);
    assign req_ready_o = (state == IDLE);
    assign addi_sel    = (state == EMIT) && pend;

    // One packer serves both halves of LI: while a trailing ADDI is owed the
    // fields come from the latched rd/low bits, otherwise from the request.
    always_comb begin
        p_fmt    = req_fmt;
        p_opcode = opcode_i;
        p_funct3 = funct3_i;
        p_rs1    = rs1_i;
        p_imm    = imm_i;
        if (addi_sel) begin
            p_fmt    = FMT_I;
            p_opcode = OP_IMM;
            p_funct3 = 3'd0;
            p_rs1    = pend_rd;
            p_imm    = {{20{pend_lo[11]}}, pend_lo};
        end else if (req_fmt == FMT_LI) begin
            p_opcode = li_small ? OP_IMM : OP_LUI;
            p_fmt    = li_small ? FMT_I : FMT_U;
            p_funct3 = 3'd0;
            p_rs1    = 5'd0;
            // Rounding by 0x800 compensates for the sign-extended ADDI low part.
            p_imm    = li_small ? imm_i : ((imm_i + 32'h0000_0800) & 32'hFFFF_F000);
        end
    end

    immenc_pack u_pack (
        .fmt      (p_fmt),
        .opcode   (p_opcode),
        .funct3   (p_funct3),
        .funct7   (funct7_i),
        .rd       (addi_sel ? pend_rd : rd_i),
        .rs1      (p_rs1),
        .rs2      (rs2_i),
        .imm      (p_imm),
        .word     (p_word),
        .in_range (in_range)
    );

`ifndef IMMENC_RANGE_CHECK_EN
    assign err_o     = 1'b0;
    assign err_cnt_o = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pend          <= 1'b0;
            pend_rd       <= '0;
            pend_lo       <= '0;
`ifdef IMMENC_RANGE_CHECK_EN
            err_o         <= 1'b0;
            err_cnt_o     <= '0;
`endif
        end else begin
`ifdef IMMENC_RANGE_CHECK_EN
            err_o <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (in_range) begin
                            instr_o       <= p_word;
                            instr_valid_o <= 1'b1;
                            state         <= EMIT;
                            pend          <= (req_fmt == FMT_LI) && !li_small &&
                                             (imm_i[11:0] != '0);
                            pend_rd       <= rd_i;
                            pend_lo       <= imm_i[11:0];
                        end
`ifdef IMMENC_RANGE_CHECK_EN
                        else begin
                            err_o <= 1'b1;
                            if (err_cnt_o != 8'hFF)
                                err_cnt_o <= err_cnt_o + 8'd1;
                        end
`endif
                    end
                end
                EMIT: begin
                    if (instr_ready_i) begin
                        if (pend) begin
                            instr_o <= p_word;
                            pend    <= 1'b0;
                            state   <= EMIT_LO;
                        end else begin
                            instr_valid_o <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                EMIT_LO: begin
                    if (instr_ready_i) begin
                        instr_valid_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    instr_valid_o <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_immenc.sv
module tb_immenc;
    import immenc_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  fmt_i = '0;
    logic [6:0]  opcode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [4:0]  rd_i = '0, rs1_i = '0, rs2_i = '0;
    logic [31:0] imm_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    int          err_q[$];
    int          exp_cnt = 0;

    immenc dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .fmt_i(fmt_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake / error pulse and checks
    // that a stalled word is held.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word = '0;
    always @(negedge clk_i) begin
        if (prev_stall && !rst_i) begin
            checks++;
            if (!instr_valid_o || instr_o !== prev_word) begin
                errors++;
                $display("FAIL hold: got valid=%0b word=%08h expected valid=1 word=%08h",
                         instr_valid_o, instr_o, prev_word);
            end
        end
        prev_stall = instr_valid_o && !instr_ready_i && !rst_i;
        prev_word  = instr_o;
        if (instr_valid_o && instr_ready_i && !rst_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected: got %08h expected none", instr_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (instr_o !== e) begin
                    errors++;
                    $display("FAIL word: got %08h expected %08h", instr_o, e);
                end
            end
        end
        if (err_o === 1'b1 && !rst_i) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL err_unexpected: got err_o=1 expected 0");
            end else begin
                void'(err_q.pop_front());
            end
        end
    end

    // Issue one request; push its expected words (n = 0 means an expected reject).
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm,
                        input int n, input logic [31:0] e0, input logic [31:0] e1);
        int cyc;
        if (n == 0) err_q.push_back(1);
        if (n >= 1) exp_q.push_back(e0);
        if (n >= 2) exp_q.push_back(e1);
        @(posedge clk_i); #1;
        fmt_i = f; opcode_i = op; funct3_i = f3; funct7_i = f7;
        rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
        req_valid_i = 1'b1;
        cyc = 0;
        while (!req_ready_o && cyc < 50) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        if (!req_ready_o) begin
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1");
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int cyc;
        cyc = 0;
        while (!(req_ready_o && !instr_valid_o) && cyc < 50) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        if (!req_ready_o) begin
            errors++;
            $display("FAIL drain_timeout: got ready=0 expected ready=1");
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_cnt", {24'd0, err_cnt_o}, 32'd0);

        // I-type ADDI x5, x0, -1: valid and word present one cycle after accept.
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1, 32'hFFF0_0293, '0);
        chk("i_latency_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("i_latency_word", instr_o, 32'hFFF0_0293);
        chk("i_err", {31'd0, err_o}, 32'd0);
        drain();
        // B, S, U, J, R formats
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1, 32'h0020_8463, '0);
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4094, 1, 32'h7E20_8FE3, '0);
        send(3'd1, 7'b0100011, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1, 32'hFE20_AE23, '0);
        send(3'd3, 7'b0110111, 3'd7, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 1, 32'h1234_50B7, '0);
        send(3'd4, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1, 32'h0010_00EF, '0);
        send(3'd4, 7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFE, 1, 32'hFFFF_F06F, '0);
        send(3'd5, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h4020_81B3, '0);
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_F800, 1, 32'h8000_0293, '0);
        // LI: two words, LUI only, ADDI only (opcode input deliberately garbage)
        send(3'd6, 7'h7F, 3'd5, 7'd0, 5'd1, 5'd3, 5'd4, 32'h1234_5FFF, 2, 32'h1234_60B7, 32'hFFF0_8093);
        send(3'd6, 7'h7F, 3'd5, 7'd0, 5'd1, 5'd3, 5'd4, 32'h0000_5000, 1, 32'h0000_50B7, '0);
        send(3'd6, 7'h7F, 3'd5, 7'd0, 5'd1, 5'd3, 5'd4, 32'hFFFF_FFFB, 1, 32'hFFB0_0093, '0);
        drain();

`ifdef IMMENC_RANGE_CHECK_EN
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048, 0, '0, '0);
        exp_cnt++;
        chk("err_pulse", {31'd0, err_o}, 32'd1);
        chk("err_novalid", {31'd0, instr_valid_o}, 32'd0);
        chk("err_cnt1", {24'd0, err_cnt_o}, exp_cnt);
        @(posedge clk_i); #1;
        chk("err_pulse_end", {31'd0, err_o}, 32'd0);
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5, 0, '0, '0);
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096, 0, '0, '0);
        send(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd0, 0, '0, '0);
        send(3'd3, 7'b0110111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1001, 0, '0, '0);
        exp_cnt += 4;
        chk("err_cnt5", {24'd0, err_cnt_o}, exp_cnt);
        for (int i = 0; i < 260; i++)
            send(3'd1, 7'b0100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F7FF, 0, '0, '0);
        chk("err_sat_pulse", {31'd0, err_o}, 32'd1);
        chk("err_sat_cnt", {24'd0, err_cnt_o}, 32'd255);
`else
        send(3'd0, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd2048, 1, 32'h8000_0293, '0);
        chk("noerr_pulse", {31'd0, err_o}, 32'd0);
        send(3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd5, 1, 32'h0020_8263, '0);
        send(3'd7, 7'b0010011, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'd0, 1, 32'h0000_0013, '0);
        drain();
        chk("noerr_cnt", {24'd0, err_cnt_o}, 32'd0);
`endif
        drain();

        // Sink stall across the LUI word.
        instr_ready_i = 1'b0;
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF, 2, 32'h1234_60B7, 32'hFFF0_8093);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stall_word", instr_o, 32'h1234_60B7);
            chk("stall_ready", {31'd0, req_ready_o}, 32'd0);
            @(posedge clk_i); #1;
        end
        instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("stall_lo_word", instr_o, 32'hFFF0_8093);
        drain();

        // Reset while the ADDI half is being presented: it must be discarded.
        instr_ready_i = 1'b0;
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1234_5FFF, 1, 32'h1234_60B7, '0);
        instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        instr_ready_i = 1'b0;
        chk("emitlo_word", instr_o, 32'hFFF0_8093);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        instr_ready_i = 1'b1;
        chk("midrst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("midrst_ready", {31'd0, req_ready_o}, 32'd1);
        chk("midrst_cnt", {24'd0, err_cnt_o}, 32'd0);
        repeat (5) @(posedge clk_i);
        #1;
        send(3'd5, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h0020_81B3, '0);
        drain();
        repeat (3) @(posedge clk_i);
        #1;
        chk("sb_words_left", exp_q.size(), 32'd0);
        chk("sb_errs_left", err_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
